// File: rtl/f16_pkg.sv
// Shared float16 definitions: field widths, exponent bias, converter state encoding
// and the packed half-precision word layout.
package f16_pkg;

    localparam int unsigned F16_BIAS  = 15;
    localparam int unsigned F16_EXP_W = 5;
    localparam int unsigned F16_MAN_W = 10;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RD_HI = 4'd1,
        RD_LO = 4'd2,
        ABS   = 4'd3,
        NORM  = 4'd4,
        RND   = 4'd5,
        WR_HI = 4'd6,
        WR_LO = 4'd7,
        DONE  = 4'd8
    } i2f_state_t;

    typedef struct packed {
        logic                 sign;
        logic [F16_EXP_W-1:0] exp;
        logic [F16_MAN_W-1:0] man;
    } f16_t;

endpackage : f16_pkg

// File: rtl/rne_round.sv
// Round-to-nearest-even on a normalized mantissa with guard/sticky bits;
// a mantissa carry-out wraps the mantissa to zero and bumps the exponent.
module rne_round
    import f16_pkg::*;
(
    input  logic [F16_MAN_W-1:0] man_i,
    input  logic                 guard_i,
    input  logic                 sticky_i,
    input  logic [F16_EXP_W-1:0] exp_i,
    output logic [F16_MAN_W-1:0] man_c_o,
    output logic [F16_EXP_W-1:0] exp_c_o
);

    localparam int unsigned SUM_W = F16_MAN_W + 1;

    logic             round_up;
    logic [SUM_W-1:0] sum;

    assign round_up = guard_i & (sticky_i | man_i[0]);
    assign sum      = {1'b0, man_i} + SUM_W'(round_up);

    // On carry-out the low mantissa bits of sum are already zero.
    always_comb begin
        man_c_o = sum[F16_MAN_W-1:0];
        exp_c_o = exp_i;
        if (sum[F16_MAN_W]) begin
            exp_c_o = exp_i + F16_EXP_W'(1);
        end
    end

endmodule : rne_round

// File: rtl/int2flt_seq.sv
// Sequential int16 -> float16 converter: reads the integer from data memory,
// normalizes one bit per cycle, rounds to nearest even and writes the result back.
module int2flt_seq
    import f16_pkg::*;
#(
    parameter logic [7:0]  SRC_ADDR = 8'd0,
    parameter logic [7:0]  DST_ADDR = 8'd2,
    parameter int unsigned BIAS     = F16_BIAS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       ack,
    output logic [7:0] dm_addr,
    output logic       dm_rd,
    output logic       dm_wr,
    output logic [7:0] dm_wdata,
    input  logic [7:0] dm_rdata
);

    localparam int unsigned EXP_TOP = 2 * BIAS;

    i2f_state_t state_q, state_d;

    logic        req_q;
    logic [7:0]  msb_q, msb_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [3:0]  sh_q, sh_d;
    f16_t        result_q, result_d;

    logic        ack_q, ack_d;
    logic [7:0]  dm_addr_q, dm_addr_d;
    logic        dm_rd_q, dm_rd_d;
    logic        dm_wr_q, dm_wr_d;
    logic [7:0]  dm_wdata_q, dm_wdata_d;

    logic [15:0]          x_c;
    logic [F16_EXP_W-1:0] exp_pre_c;
    logic [F16_MAN_W-1:0] rnd_man_c;
    logic [F16_EXP_W-1:0] rnd_exp_c;

    assign x_c       = {msb_q, dm_rdata};
    assign exp_pre_c = F16_EXP_W'(EXP_TOP) - F16_EXP_W'(sh_q);

    rne_round u_rne_round (
        .man_i    (mag_q[14:5]),
        .guard_i  (mag_q[4]),
        .sticky_i (|mag_q[3:0]),
        .exp_i    (exp_pre_c),
        .man_c_o  (rnd_man_c),
        .exp_c_o  (rnd_exp_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            msb_q      <= '0;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            sh_q       <= '0;
            result_q   <= '0;
            ack_q      <= 1'b0;
            dm_addr_q  <= '0;
            dm_rd_q    <= 1'b0;
            dm_wr_q    <= 1'b0;
            dm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req;
            msb_q      <= msb_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            sh_q       <= sh_d;
            result_q   <= result_d;
            ack_q      <= ack_d;
            dm_addr_q  <= dm_addr_d;
            dm_rd_q    <= dm_rd_d;
            dm_wr_q    <= dm_wr_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    // Next state and datapath; memory read data lags the address by one cycle.
    always_comb begin
        state_d  = state_q;
        msb_d    = msb_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        sh_d     = sh_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (req_q && !req) begin
                    state_d = RD_HI;
                end
            end
            RD_HI: state_d = RD_LO;
            RD_LO: begin
                msb_d   = dm_rdata;
                state_d = ABS;
            end
            ABS: begin
                sign_d = x_c[15];
                mag_d  = x_c[15] ? (~x_c + 16'd1) : x_c;
                sh_d   = '0;
                if (mag_d == 16'd0) begin
                    result_d = '0;
                    state_d  = WR_HI;
                end else begin
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (mag_q[15]) begin
                    state_d = RND;
                end else begin
                    mag_d = {mag_q[14:0], 1'b0};
                    sh_d  = sh_q + 4'd1;
                end
            end
            RND: begin
                result_d = '{sign: sign_q, exp: rnd_exp_c, man: rnd_man_c};
                state_d  = WR_HI;
            end
            WR_HI: state_d = WR_LO;
            WR_LO: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port values are decoded from the upcoming state so they register cleanly.
    always_comb begin
        ack_d      = 1'b0;
        dm_addr_d  = '0;
        dm_rd_d    = 1'b0;
        dm_wr_d    = 1'b0;
        dm_wdata_d = '0;

        unique case (state_d)
            RD_HI: begin
                dm_addr_d = SRC_ADDR;
                dm_rd_d   = 1'b1;
            end
            RD_LO: begin
                dm_addr_d = SRC_ADDR + 8'd1;
                dm_rd_d   = 1'b1;
            end
            WR_HI: begin
                dm_addr_d  = DST_ADDR;
                dm_wdata_d = result_d[15:8];
                dm_wr_d    = 1'b1;
            end
            WR_LO: begin
                dm_addr_d  = DST_ADDR + 8'd1;
                dm_wdata_d = result_d[7:0];
                dm_wr_d    = 1'b1;
            end
            DONE: ack_d = 1'b1;
            default: ;
        endcase
    end

    assign ack      = ack_q;
    assign dm_addr  = dm_addr_q;
    assign dm_rd    = dm_rd_q;
    assign dm_wr    = dm_wr_q;
    assign dm_wdata = dm_wdata_q;

endmodule : int2flt_seq
